// File: rtl/rem_pkg.sv
// rem_pkg: definitions shared by the reminder timer and the alert controller.
//   state_t   - alert controller FSM states
//   DUR_W     - width of the reminder duration bus (shared with the timer)
//   MISSED_W  - width of the missed-alert counter
//   sat_inc_missed - saturating increment for the missed-alert counter
package rem_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ALERT      = 2'd1,
        SNOOZE_REQ = 2'd2,
        SNOOZED    = 2'd3
    } state_t;

    localparam int DUR_W    = 32;
    localparam int MISSED_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [MISSED_W-1:0] sat_inc_missed(input logic [MISSED_W-1:0] v);
        logic [MISSED_W-1:0] r;
        if (v == {MISSED_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(MISSED_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/rem_alert_ctrl_blink_gen.sv
// blink_gen: square-wave generator for the user alarm LED.
//   clk, rst  - clock, synchronous active-high reset
//   enable    - blink while high; output forced low while low
//   load      - restart the wave: output 1, phase counter cleared
//   alarm     - registered blink output, BLINK_HALF cycles high then low
module blink_gen #(
    parameter int BLINK_HALF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic load,
    output logic alarm
);

    localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_r;

    // Phase counter and output toggle; load has priority over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            alarm <= 1'b0;
        end else if (load) begin
            cnt_r <= '0;
            alarm <= 1'b1;
        end else if (enable) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= '0;
                alarm <= ~alarm;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r <= '0;
            alarm <= 1'b0;
        end
    end

endmodule

// File: rtl/rem_alert_ctrl.sv
// rem_alert_ctrl: turns the reminder timer's notif level into a blinking
// alarm the user can acknowledge or snooze; unanswered alerts are counted.
//   clk, rst    - clock, synchronous active-high reset
//   notif       - reminder-expired level (only its rising edge matters)
//   ack         - user acknowledge
//   snooze      - user snooze request
//   alarm       - blinking alert indicator
//   set_out     - one-cycle re-arm pulse to the reminder timer
//   dur_out     - re-arm duration, holds last value between pulses
//   busy        - high whenever the controller is not idle
//   missed_cnt  - saturating count of timed-out alerts
module rem_alert_ctrl
    import rem_pkg::*;
#(
    parameter logic [DUR_W-1:0] SNOOZE_DUR = 32'd30,
    parameter int               MAX_SNOOZE = 3,
    parameter int               TIMEOUT    = 100,
    parameter int               BLINK_HALF = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                notif,
    input  logic                ack,
    input  logic                snooze,
    output logic                alarm,
    output logic                set_out,
    output logic [DUR_W-1:0]    dur_out,
    output logic                busy,
    output logic [MISSED_W-1:0] missed_cnt
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_ONE   = TW'(1);
    localparam logic [SW-1:0] S_MAX   = SW'(MAX_SNOOZE);
    localparam logic [SW-1:0] S_ONE   = SW'(1);

    state_t        state_r;
    state_t        next_state_s;
    logic          notif_q_r;
    logic          notif_edge_s;
    logic [TW-1:0] tcnt_r;
    logic [SW-1:0] snz_cnt_r;

    logic tcnt_clr_s;
    logic tcnt_inc_s;
    logic snz_clr_s;
    logic snz_inc_s;
    logic miss_s;
    logic blink_load_s;
    logic blink_en_s;

    assign notif_edge_s = notif & ~notif_q_r;

    // Next-state decision; in ALERT the order is ack, snooze, timeout, new notif.
    always_comb begin
        next_state_s = state_r;
        tcnt_clr_s   = 1'b0;
        tcnt_inc_s   = 1'b0;
        snz_clr_s    = 1'b0;
        snz_inc_s    = 1'b0;
        miss_s       = 1'b0;
        blink_load_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (notif_edge_s) begin
                    next_state_s = ALERT;
                    tcnt_clr_s   = 1'b1;
                    blink_load_s = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ALERT: begin
                if (ack) begin
                    next_state_s = IDLE;
                    snz_clr_s    = 1'b1;
                end else if (snooze && (snz_cnt_r < S_MAX)) begin
                    next_state_s = SNOOZE_REQ;
                end else if (tcnt_r == T_LAST) begin
                    // An exhausted-snooze request counts as no input here.
                    next_state_s = IDLE;
                    miss_s       = 1'b1;
                    snz_clr_s    = 1'b1;
                end else if (notif_edge_s) begin
                    // A fresh reminder restarts the timeout but not the blink phase.
                    tcnt_clr_s   = 1'b1;
                end else begin
                    tcnt_inc_s   = 1'b1;
                end
            end
            SNOOZE_REQ: begin
                next_state_s = SNOOZED;
                snz_inc_s    = 1'b1;
            end
            SNOOZED: begin
                if (ack) begin
                    next_state_s = IDLE;
                    snz_clr_s    = 1'b1;
                end else if (notif_edge_s) begin
                    next_state_s = ALERT;
                    tcnt_clr_s   = 1'b1;
                    blink_load_s = 1'b1;
                end else begin
                    next_state_s = SNOOZED;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        blink_en_s = (next_state_s == ALERT);
    end

    // State, counters, edge-detect history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            notif_q_r  <= 1'b0;
            tcnt_r     <= '0;
            snz_cnt_r  <= '0;
            set_out    <= 1'b0;
            dur_out    <= '0;
            busy       <= 1'b0;
            missed_cnt <= '0;
        end else begin
            state_r   <= next_state_s;
            notif_q_r <= notif;
            if (tcnt_clr_s) begin
                tcnt_r <= '0;
            end else if (tcnt_inc_s) begin
                tcnt_r <= tcnt_r + T_ONE;
            end else begin
                tcnt_r <= tcnt_r;
            end
            if (snz_clr_s) begin
                snz_cnt_r <= '0;
            end else if (snz_inc_s && (snz_cnt_r < S_MAX)) begin
                snz_cnt_r <= snz_cnt_r + S_ONE;
            end else begin
                snz_cnt_r <= snz_cnt_r;
            end
            if (miss_s) begin
                missed_cnt <= sat_inc_missed(missed_cnt);
            end else begin
                missed_cnt <= missed_cnt;
            end
            set_out <= (next_state_s == SNOOZE_REQ);
            if (next_state_s == SNOOZE_REQ) begin
                dur_out <= SNOOZE_DUR;
            end else begin
                dur_out <= dur_out;
            end
            busy <= (next_state_s != IDLE);
        end
    end

    blink_gen #(
        .BLINK_HALF (BLINK_HALF)
    ) u_blink (
        .clk    (clk),
        .rst    (rst),
        .enable (blink_en_s),
        .load   (blink_load_s),
        .alarm  (alarm)
    );

endmodule

// File: tb/tb_rem_alert_ctrl.sv
module tb_rem_alert_ctrl;

    localparam int MAXS  = 3;
    localparam int TOUT  = 100;
    localparam int BHALF = 4;
    localparam int SDUR  = 30;

    logic        clk;
    logic        rst;
    logic        notif;
    logic        ack;
    logic        snooze;
    logic        alarm;
    logic        set_out;
    logic [31:0] dur_out;
    logic        busy;
    logic [7:0]  missed_cnt;

    int errors = 0;
    int checks = 0;

    rem_alert_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .notif      (notif),
        .ack        (ack),
        .snooze     (snooze),
        .alarm      (alarm),
        .set_out    (set_out),
        .dur_out    (dur_out),
        .busy       (busy),
        .missed_cnt (missed_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // mode: 0 idle, 1 alerting, 2 re-arm request cycle, 3 snoozed
    int m_mode      = 0;
    int m_alert_age = 0;   // cycles since alert (re)started the timeout
    int m_blink_age = 0;   // cycles since the alarm was switched on
    int m_snoozes   = 0;
    int m_missed    = 0;
    int m_prev      = 0;
    int m_set       = 0;
    int m_dur       = 0;

    task automatic model_step(input logic r, input logic n, input logic a, input logic s);
        int edge_seen;
        if (r) begin
            m_mode = 0; m_alert_age = 0; m_blink_age = 0; m_snoozes = 0;
            m_missed = 0; m_prev = 0; m_set = 0; m_dur = 0;
            return;
        end
        edge_seen = (n && (m_prev == 0)) ? 1 : 0;
        m_prev = n ? 1 : 0;
        if (m_mode == 0) begin
            if (edge_seen != 0) begin
                m_mode = 1; m_alert_age = 0; m_blink_age = 0;
            end
        end else if (m_mode == 1) begin
            if (a) begin
                m_mode = 0; m_snoozes = 0;
            end else if (s && m_snoozes < MAXS) begin
                m_mode = 2;
            end else if (m_alert_age + 1 >= TOUT) begin
                m_mode = 0; m_snoozes = 0;
                m_missed = (m_missed >= 255) ? 255 : m_missed + 1;
            end else begin
                m_blink_age++;
                m_alert_age = (edge_seen != 0) ? 0 : m_alert_age + 1;
            end
        end else if (m_mode == 2) begin
            m_mode = 3; m_snoozes++;
        end else begin
            if (a) begin
                m_mode = 0; m_snoozes = 0;
            end else if (edge_seen != 0) begin
                m_mode = 1; m_alert_age = 0; m_blink_age = 0;
            end
        end
        m_set = (m_mode == 2) ? 1 : 0;
        if (m_mode == 2) m_dur = SDUR;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model after each edge.
    task automatic compare_all();
        int exp_alarm;
        exp_alarm = (m_mode == 1 && ((m_blink_age / BHALF) % 2) == 0) ? 1 : 0;
        check("alarm",      {31'd0, alarm},      exp_alarm);
        check("busy",       {31'd0, busy},       (m_mode != 0) ? 1 : 0);
        check("set_out",    {31'd0, set_out},    m_set);
        check("dur_out",    dur_out,             m_dur);
        check("missed_cnt", {24'd0, missed_cnt}, m_missed);
    endtask

    task automatic cycle(input logic r, input logic n, input logic a, input logic s);
        rst = r; notif = n; ack = a; snooze = s;
        @(posedge clk);
        model_step(r, n, a, s);
        #1;
        compare_all();
    endtask

    // One timed-out alert: drop/raise notif, then wait for the return to idle.
    task automatic timeout_alert(output int k);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        k = 0;
        while (busy === 1'b1 && k < 200) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            k++;
        end
    endtask

    initial begin
        int k;
        logic [7:0] pat;
        logic rr, nn, aa, ss;
        rst = 1'b1; notif = 1'b0; ack = 1'b0; snooze = 1'b0;

        // reset
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_alarm", {31'd0, alarm}, 32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_dur",   dur_out,        32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // basic alert and blink pattern
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("alert_alarm", {31'd0, alarm}, 32'd1);
        check("alert_busy",  {31'd0, busy},  32'd1);
        pat = 8'd0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            pat[7-i] = alarm;
        end
        check("blink_pattern", {24'd0, pat}, 32'h0000_00E1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("ack_alarm",  {31'd0, alarm},      32'd0);
        check("ack_busy",   {31'd0, busy},       32'd0);
        check("ack_missed", {24'd0, missed_cnt}, 32'd0);

        // three snoozes allowed, each re-alerting on a new notif edge
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1);
            check("snz_set",   {31'd0, set_out}, 32'd1);
            check("snz_dur",   dur_out,          32'd30);
            check("snz_alarm", {31'd0, alarm},   32'd0);
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            check("snz_set_fall", {31'd0, set_out}, 32'd0);
            check("snz_busy",     {31'd0, busy},    32'd1);
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            check("realert_alarm", {31'd0, alarm}, 32'd1);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("snz_limit_set",  {31'd0, set_out}, 32'd0);
        check("snz_limit_busy", {31'd0, busy},    32'd1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("snz_after_ack_set", {31'd0, set_out}, 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("snoozed_ack_busy", {31'd0, busy}, 32'd0);

        // simultaneous ack and snooze
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check("ack_snz_busy", {31'd0, busy},    32'd0);
        check("ack_snz_set",  {31'd0, set_out}, 32'd0);

        // notif held high after ack never re-alerts
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("level_no_realert", {31'd0, busy}, 32'd0);

        // timeout and saturation
        timeout_alert(k);
        check("timeout_cycles", k, 32'd100);
        check("timeout_missed", {24'd0, missed_cnt}, 32'd1);
        for (int i = 0; i < 255; i++) begin
            timeout_alert(k);
            if (k >= 200) check("timeout_bound", k, 32'd100);
        end
        check("missed_saturate", {24'd0, missed_cnt}, 32'd255);

        // reset in SNOOZE_REQ
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("mrst_set",    {31'd0, set_out},    32'd0);
        check("mrst_dur",    dur_out,             32'd0);
        check("mrst_missed", {24'd0, missed_cnt}, 32'd0);
        check("mrst_busy",   {31'd0, busy},       32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("mrst_no_stray_set", {31'd0, set_out}, 32'd0);

        // reset in ALERT
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("arst_alarm", {31'd0, alarm}, 32'd0);
        check("arst_busy",  {31'd0, busy},  32'd0);

        // randomized traffic
        nn = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rr = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 11) == 0) nn = ~nn;
            aa = ($urandom_range(0, 39) == 0);
            ss = ($urandom_range(0, 14) == 0);
            cycle(rr, nn, aa, ss);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rem_alert_ctrl.md
# rem_alert_ctrl

Alert-side controller for the reminder system: consumes the `notif` output of the reminder timer and turns it into a blinking user alarm. The user can acknowledge or snooze the alert. A snooze re-arms the reminder timer through its `set`/`dur` inputs, and an alert left unanswered times out and is counted as missed. The block sits between the reminder timer and the user push-button/LED logic.

## Interface
- `SNOOZE_DUR`, 32'd30: duration driven on `dur_out` for each snooze.
- `MAX_SNOOZE`, 3: snoozes allowed per reminder; further snooze requests are ignored.
- `TIMEOUT`, 100: cycles an alert may stay unanswered before it is counted as missed.
- `BLINK_HALF`, 4: alarm half-period in cycles.
- `clk`, in, 1: clock, all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `notif`, in, 1: reminder-expired level from the reminder timer.
- `ack`, in, 1: user acknowledge; single-cycle or level.
- `snooze`, in, 1: user snooze request; single-cycle or level.
- `alarm`, out, 1: blinking alert indicator.
- `set_out`, out, 1: one-cycle re-arm pulse to the reminder timer's `set`.
- `dur_out`, out, 32: duration to the reminder timer's `dur`.
- `busy`, out, 1: high in every state except IDLE.
- `missed_cnt`, out, 8: count of timed-out alerts; saturates at 255.

## Operation
- A rising edge of `notif` (`notif` & ~`notif_q`, with `notif_q` registered) is the only alert trigger. A level held high never re-triggers.
- **IDLE**
  - `alarm`=0.
  - A `notif` edge → ALERT; the timeout counter and blink counter clear and `alarm` is loaded to 1.
- **ALERT**
  - `alarm` toggles every `BLINK_HALF` cycles, starting at 1.
  - Timeout counter increments each cycle.
  - Priority per cycle: `ack` > `snooze` > timeout > `notif` edge.
  - `ack` → IDLE; `snooze_cnt` clears.
  - `snooze` with `snooze_cnt` < `MAX_SNOOZE` → SNOOZE_REQ.
  - `snooze` with `snooze_cnt` = `MAX_SNOOZE` is ignored; the state stays ALERT and blinking continues.
  - Timeout counter reaching `TIMEOUT`-1 with no `ack`/`snooze` → IDLE; `missed_cnt` increments (saturating) and `snooze_cnt` clears.
  - A new `notif` edge while in ALERT restarts the timeout counter only.
- **SNOOZE_REQ** (exactly one cycle)
  - `set_out`=1 and `dur_out`=`SNOOZE_DUR`.
  - `snooze_cnt` increments.
  - → SNOOZED.
- **SNOOZED**
  - `alarm`=0; waits for the next `notif` edge → ALERT.
  - `ack` → IDLE and clears `snooze_cnt`. A later `notif` edge is then treated as a new reminder.
- `dur_out` holds its last driven value between pulses; it is 0 after reset.
- `snooze_cnt` is internal, ranges 0..`MAX_SNOOZE`, and never wraps.

## Timing
- Reset values: state IDLE, `alarm`=0, `set_out`=0, `dur_out`=0, `busy`=0, `missed_cnt`=0, `snooze_cnt`=0, `notif_q`=0.
- Reset mid-operation restores all reset values on the next edge. Input events in the reset cycle are discarded.
- All outputs are registered.
- Alert latency: `notif` rises before edge N → `alarm`=1 and `busy`=1 after edge N.
- Blink: `alarm` is high for `BLINK_HALF` cycles, then low for `BLINK_HALF` cycles, and so on.
- Snooze latency:
  - `snooze` sampled at edge N → SNOOZE_REQ after edge N, with `alarm`=0 and `set_out`=1.
  - `set_out` falls after edge N+1.
- Ack latency: `ack` sampled at edge N → `alarm`=0 and `busy`=0 after edge N.
- Timeout: with no user input, the return to IDLE and the `missed_cnt` increment occur `TIMEOUT` cycles after entering ALERT.
- Simultaneous `ack` and `snooze` → `ack` wins.
- `ack` on the timeout cycle → acknowledged, not missed.

## Structure
- Shared package `rem_pkg` holds:
  - the state enum {IDLE, ALERT, SNOOZE_REQ, SNOOZED};
  - the duration width constant (32), also shared with the reminder timer;
  - the `missed_cnt` width (8).
- One sub-module, `blink_gen`: enable input, `BLINK_HALF` parameter, clears to output 1 on a synchronous load, drives `alarm`.
- The FSM, timeout counter, snooze counter and edge detector stay in `rem_alert_ctrl`.

## Test plan
- **Basic alert:** reset for 2 cycles, then raise `notif` → `alarm`=1 one edge later and toggles every 4 cycles; `ack` → `alarm`=0, `busy`=0 next edge; `missed_cnt`=0.
- **Snooze:** during ALERT pulse `snooze` → `set_out` is a single 1-cycle pulse with `dur_out`=30 and state SNOOZED; drop and re-raise `notif` → ALERT again.
- **Snooze limit:** snooze 3 times, then a 4th `snooze` → no `set_out` pulse and `alarm` keeps blinking; `ack` → IDLE with `snooze_cnt` cleared (a following alert allows 3 snoozes again).
- **Timeout:** raise `notif` and never respond → IDLE after 100 cycles with `missed_cnt`=1; repeat 256 alerts → `missed_cnt` saturates at 255.
- **Simultaneous / level inputs:**
  - `ack` and `snooze` in the same cycle → IDLE with no `set_out`.
  - `notif` held high for 300 cycles after `ack` → no re-alert.
- **Mid-operation reset:** assert `rst` while in SNOOZE_REQ and while in ALERT → all outputs return to their reset values on the next edge, `missed_cnt` returns to 0, and no stray `set_out`.
